// File: rtl/tick_generator_pkg.sv
// tick_gen_pkg: shared mode type, channel-index sizing and parameter range checks
package tick_gen_pkg;

   typedef enum logic {
      PULSE  = 1'b0,
      SQUARE = 1'b1
   } tick_mode_e;

   localparam int MAX_CH   = 16;
   localparam int CH_W_MAX = 4;

   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic bit num_ch_ok(input int num_ch);
      return (num_ch >= 1) && (num_ch <= MAX_CH) && (ch_idx_w(num_ch) <= CH_W_MAX);
   endfunction

   function automatic bit default_div_ok(input int width, input longint div);
      return (width >= 1) && (width < 63) && (div >= 0) && (div < (longint'(1) << width));
   endfunction

endpackage

// File: rtl/tick_generator_if.sv
// tick_generator_if: run-time configuration request channel of the tick generator
interface tick_generator_if
   import tick_gen_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 16
);

   localparam int CW = ch_idx_w(NUM_CH);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CW-1:0]    cfg_chan;
   logic [WIDTH-1:0] cfg_div;
   tick_mode_e       cfg_mode;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_chan, cfg_div, cfg_mode,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_chan, cfg_div, cfg_mode,
      output cfg_ready, cfg_err
   );

endinterface

// File: rtl/tick_generator_channel.sv
// tick_channel: one divider channel with active/shadow config and PULSE/SQUARE decode
module tick_channel
   import tick_gen_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_div,
   input  tick_mode_e       wr_mode,
   output logic             pending,
   output logic             tick
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] sh_div_q, sh_div_d;
   tick_mode_e       mode_q, mode_d;
   tick_mode_e       sh_mode_q, sh_mode_d;
   logic             pend_q, pend_d;
   logic             halted, last, wrap, apply;

   // Boundary detection; a pending update lands only where no runt period can result
   always_comb begin
      halted    = div_q == '0;
      last      = !halted && (cnt_q == div_q - WIDTH'(1));
      wrap      = en && last;
      apply     = pend_q && (wrap || !en || halted || restart);
      cnt_d     = (apply || restart || halted || wrap) ? '0 : (en ? cnt_q + WIDTH'(1) : cnt_q);
      div_d     = apply ? sh_div_q : div_q;
      mode_d    = apply ? sh_mode_q : mode_q;
      pend_d    = apply ? 1'b0 : (pend_q || wr);
      sh_div_d  = wr ? wr_div : sh_div_q;
      sh_mode_d = wr ? wr_mode : sh_mode_q;
   end

   // Outputs decode straight from registered state; PULSE is also gated by the live enable
   always_comb begin
      tick    = (mode_q == SQUARE) ? (!halted && (cnt_q >= (div_q >> 1))) : wrap;
      pending = pend_q;
   end

   // Channel state; reset restores the default divisor in PULSE mode and drops any update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         div_q     <= DEF_DIV;
         mode_q    <= PULSE;
         sh_div_q  <= DEF_DIV;
         sh_mode_q <= PULSE;
         pend_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         mode_q    <= mode_d;
         sh_div_q  <= sh_div_d;
         sh_mode_q <= sh_mode_d;
         pend_q    <= pend_d;
      end
   end

endmodule

// File: rtl/tick_generator.sv
// tick_generator: NUM_CH run-time programmable tick / clock-enable channels with config decode
module tick_generator
   import tick_gen_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync_restart,
   tick_generator_if.slave   cfg,
   output logic [NUM_CH-1:0] pending,
   output logic [NUM_CH-1:0] tick
);

   localparam int CW = ch_idx_w(NUM_CH);
   localparam int NP = 1 << CW;
   localparam logic [NP-1:0] IN_RANGE = NP'({NUM_CH{1'b1}});

   if (!num_ch_ok(NUM_CH) || !default_div_ok(WIDTH, DEFAULT_DIV)) begin : g_bad_param
      $error("tick_generator: NUM_CH must be 1..16 and DEFAULT_DIV must fit in WIDTH bits");
   end

   logic [NP-1:0]     pend_pad, sel;
   logic [NUM_CH-1:0] wr;
   logic              in_range, ready, accept;
   logic              err_q, err_d;

   // Config decode: padded lookups keep out-of-range channel numbers harmless
   always_comb begin
      pend_pad      = NP'(pending);
      in_range      = IN_RANGE[cfg.cfg_chan];
      ready         = !in_range || !pend_pad[cfg.cfg_chan];
      accept        = cfg.cfg_valid && ready;
      sel           = NP'(1) << cfg.cfg_chan;
      wr            = (accept && in_range) ? sel[NUM_CH-1:0] : '0;
      err_d         = accept && !in_range;
      cfg.cfg_ready = ready;
   end

   // An accepted request for a missing channel is dropped and flagged one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else err_q <= err_d;
   end

   assign cfg.cfg_err = err_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tick_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (ch_en[i]),
         .restart (sync_restart),
         .wr      (wr[i]),
         .wr_div  (cfg.cfg_div),
         .wr_mode (cfg.cfg_mode),
         .pending (pending[i]),
         .tick    (tick[i])
      );
   end

endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: vector table, corner sequences and random traffic checked through a scoreboard
module tb_tick_generator;
   import tick_gen_pkg::*;

   localparam int NC = 5;
   localparam int W  = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NC-1:0] ch_en;
   logic          sync_restart;
   logic [NC-1:0] pending;
   logic [NC-1:0] tick;

   int total = 0;
   int bad   = 0;

   tick_generator_if #(.NUM_CH(NC), .WIDTH(W)) bus ();

   tick_generator #(.NUM_CH(NC), .WIDTH(W), .DEFAULT_DIV(4)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ch_en        (ch_en),
      .sync_restart (sync_restart),
      .cfg          (bus),
      .pending      (pending),
      .tick         (tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NC-1:0] en;
      logic          sr;
      logic          v;
      logic [2:0]    ch;
      logic [W-1:0]  div;
      logic          mode;
      logic [NC-1:0] tick;
      logic [NC-1:0] pend;
      logic          rdy;
      logic          err;
   } vec_t;

   typedef struct packed {
      logic [NC-1:0] tick;
      logic [NC-1:0] pend;
      logic          rdy;
      logic          err;
   } exp_t;

   exp_t exp_q[$];
   vec_t tab[18];

   int m_cnt[NC];
   int m_d[NC];
   int m_sd[NC];
   bit m_mode[NC];
   bit m_smode[NC];
   bit m_pend[NC];
   bit m_err;

   logic [NC-1:0] obs_tick;
   logic [NC-1:0] obs_pend;
   logic          obs_rdy;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int en, input int sr, input int v, input int ch, input int div, input int mode);
      vec_t r = '0;
      r.en   = NC'(en);
      r.sr   = 1'(sr);
      r.v    = 1'(v);
      r.ch   = 3'(ch);
      r.div  = W'(div);
      r.mode = 1'(mode);
      return r;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NC; i++) begin
         m_cnt[i]   = 0;
         m_d[i]     = 4;
         m_sd[i]    = 4;
         m_mode[i]  = 1'b0;
         m_smode[i] = 1'b0;
         m_pend[i]  = 1'b0;
      end
      m_err = 1'b0;
   endfunction

   // Expected outputs for the cycle about to be sampled, from the model state and live inputs
   function automatic exp_t model_exp(input vec_t v);
      exp_t e = '0;
      int   c = int'(v.ch);
      for (int i = 0; i < NC; i++) begin
         if (m_d[i] == 0) e.tick[i] = 1'b0;
         else if (m_mode[i]) e.tick[i] = m_cnt[i] >= m_d[i] / 2;
         else e.tick[i] = v.en[i] && (m_cnt[i] == m_d[i] - 1);
         e.pend[i] = m_pend[i];
      end
      if (c >= NC) e.rdy = 1'b1;
      else e.rdy = !m_pend[c];
      e.err = m_err;
      return e;
   endfunction

   // Advance the model across one rising edge
   function automatic void model_clock(input vec_t v);
      int c = int'(v.ch);
      bit acc;
      bit wrap;
      bit app;
      if (c >= NC) acc = v.v;
      else acc = v.v && !m_pend[c];
      for (int i = 0; i < NC; i++) begin
         wrap = v.en[i] && (m_d[i] != 0) && (m_cnt[i] == m_d[i] - 1);
         app  = m_pend[i] && (wrap || !v.en[i] || m_d[i] == 0 || v.sr);
         if (app) begin
            m_d[i]    = m_sd[i];
            m_mode[i] = m_smode[i];
            m_pend[i] = 1'b0;
            m_cnt[i]  = 0;
         end else if (v.sr || m_d[i] == 0 || wrap) begin
            m_cnt[i] = 0;
         end else if (v.en[i]) begin
            m_cnt[i] = m_cnt[i] + 1;
         end
         if (acc && c == i) begin
            m_sd[i]    = int'(v.div);
            m_smode[i] = v.mode;
            m_pend[i]  = 1'b1;
         end
      end
      m_err = acc && (c >= NC);
   endfunction

   // One cycle: drive at posedge+1, queue the expectation, compare at posedge+3, then clock
   task automatic step(input vec_t v, input bit from_tab, input string n);
      exp_t e;
      ch_en         = v.en;
      sync_restart  = v.sr;
      bus.cfg_valid = v.v;
      bus.cfg_chan  = v.ch;
      bus.cfg_div   = v.div;
      bus.cfg_mode  = tick_mode_e'(v.mode);
      if (from_tab) begin
         e.tick = v.tick;
         e.pend = v.pend;
         e.rdy  = v.rdy;
         e.err  = v.err;
      end else begin
         e = model_exp(v);
      end
      exp_q.push_back(e);
      #2;
      e = exp_q.pop_front();
      chk({n, ".tick"}, 32'(tick), 32'(e.tick));
      chk({n, ".pending"}, 32'(pending), 32'(e.pend));
      chk({n, ".ready"}, 32'(bus.cfg_ready), 32'(e.rdy));
      chk({n, ".err"}, 32'(bus.cfg_err), 32'(e.err));
      obs_tick = tick;
      obs_pend = pending;
      obs_rdy  = bus.cfg_ready;
      @(posedge clk);
      model_clock(v);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      ch_en         = '0;
      sync_restart  = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_chan  = '0;
      bus.cfg_div   = '0;
      bus.cfg_mode  = PULSE;
      model_reset();

      // Directed table: default D=4 PULSE on ch0, then out-of-range requests
      for (int k = 0; k < 12; k++) begin
         tab[k]      = mk(5'b00001, 0, 0, 0, 0, 0);
         tab[k].tick = (k % 4 == 3) ? NC'(1) : '0;
         tab[k].rdy  = 1'b1;
      end
      tab[12] = mk(5'b00001, 0, 1, 5, 9, 1); tab[12].rdy = 1'b1;
      tab[13] = mk(5'b00001, 0, 0, 0, 0, 0); tab[13].rdy = 1'b1; tab[13].err = 1'b1;
      tab[14] = mk(5'b00001, 0, 0, 0, 0, 0); tab[14].rdy = 1'b1;
      tab[15] = mk(5'b00001, 0, 0, 0, 0, 0); tab[15].rdy = 1'b1; tab[15].tick = NC'(1);
      tab[16] = mk(5'b00001, 0, 1, 7, 0, 0); tab[16].rdy = 1'b1;
      tab[17] = mk(5'b00001, 0, 0, 7, 0, 0); tab[17].rdy = 1'b1; tab[17].err = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("reset.tick", 32'(tick), 0);
      chk("reset.pending", 32'(pending), 0);
      chk("reset.err", 32'(bus.cfg_err), 0);
      ch_en = '1;
      @(posedge clk);
      #1;
      chk("reset_en.tick", 32'(tick), 0);
      rst_n = 1'b1;

      for (int k = 0; k < 18; k++) step(tab[k], 1'b1, $sformatf("vec%0d", k));

      // ch1 D=6 SQUARE written mid-period: old period completes, then 3 low / 3 high
      step(mk(5'b00011, 0, 0, 1, 0, 0), 1'b0, "a_run");
      step(mk(5'b00011, 0, 0, 1, 0, 0), 1'b0, "a_run");
      step(mk(5'b00011, 0, 1, 1, 6, 1), 1'b0, "a_wr");
      step(mk(5'b00011, 0, 0, 1, 0, 0), 1'b0, "a_hold");
      chk("a_hold.pending1", 32'(obs_pend[1]), 1);
      chk("a_hold.ready1", 32'(obs_rdy), 0);
      chk("a_hold.last_pulse", 32'(obs_tick[1]), 1);
      for (int k = 0; k < 12; k++) begin
         step(mk(5'b00011, 0, 0, 1, 0, 0), 1'b0, "a_sq");
         chk($sformatf("a_square%0d", k), 32'(obs_tick[1]), 32'((k % 6) >= 3));
      end

      // ch2 frozen at cnt=2 for five cycles, fires one cycle after re-enable
      step(mk(5'b00111, 0, 0, 0, 0, 0), 1'b0, "b_run");
      step(mk(5'b00111, 0, 0, 0, 0, 0), 1'b0, "b_run");
      for (int k = 0; k < 5; k++) begin
         step(mk(5'b00011, 0, 0, 0, 0, 0), 1'b0, "b_off");
         chk("b_off.tick2", 32'(obs_tick[2]), 0);
      end
      step(mk(5'b00111, 0, 0, 0, 0, 0), 1'b0, "b_on");
      chk("b_on.tick2", 32'(obs_tick[2]), 0);
      step(mk(5'b00111, 0, 0, 0, 0, 0), 1'b0, "b_fire");
      chk("b_fire.tick2", 32'(obs_tick[2]), 1);

      // ch3: D=1 applied while disabled, then D=0 halt, then a pending update applies at once
      step(mk(5'b00111, 0, 1, 3, 1, 0), 1'b0, "c_wr1");
      step(mk(5'b00111, 0, 0, 3, 0, 0), 1'b0, "c_app1");
      chk("c_app1.pending3", 32'(obs_pend[3]), 1);
      for (int k = 0; k < 4; k++) begin
         step(mk(5'b01111, 0, 0, 3, 0, 0), 1'b0, "c_d1");
         chk("c_d1.tick3", 32'(obs_tick[3]), 1);
      end
      step(mk(5'b01111, 0, 1, 3, 0, 0), 1'b0, "c_wr0");
      step(mk(5'b01111, 0, 0, 3, 0, 0), 1'b0, "c_app0");
      chk("c_app0.pending3", 32'(obs_pend[3]), 1);
      for (int k = 0; k < 2; k++) begin
         step(mk(5'b01111, 0, 0, 3, 0, 0), 1'b0, "c_halt");
         chk("c_halt.tick3", 32'(obs_tick[3]), 0);
      end
      step(mk(5'b01111, 0, 1, 3, 5, 0), 1'b0, "c_wr5");
      step(mk(5'b01111, 0, 0, 3, 0, 0), 1'b0, "c_app5");
      chk("c_app5.pending3", 32'(obs_pend[3]), 1);
      step(mk(5'b01111, 0, 0, 3, 0, 0), 1'b0, "c_done");
      chk("c_done.pending3", 32'(obs_pend[3]), 0);

      // sync_restart with a coincident write to ch4: restart zeroes counters, write stays pending
      step(mk(5'b01111, 0, 0, 0, 0, 0), 1'b0, "d_run");
      step(mk(5'b11111, 1, 1, 4, 3, 0), 1'b0, "d_sr");
      for (int k = 0; k < 6; k++) begin
         step(mk(5'b11111, 0, 0, 4, 0, 0), 1'b0, "d_after");
         chk($sformatf("d_tick0_%0d", k), 32'(obs_tick[0]), 32'(k == 3));
         chk($sformatf("d_tick3_%0d", k), 32'(obs_tick[3]), 32'(k == 4));
         if (k == 0) chk("d_after.pending4", 32'(obs_pend[4]), 1);
         if (k == 4) chk("d_applied.pending4", 32'(obs_pend[4]), 0);
      end

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         step(mk(int'($urandom | $urandom) & 31, ($urandom_range(0, 19) == 0) ? 1 : 0,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 1))), 1'b0, "rnd");
      end

      // Asynchronous reset in mid-period with an update pending
      step(mk(0, 0, 0, 0, 0, 0), 1'b0, "e_flush");
      step(mk(0, 0, 0, 0, 0, 0), 1'b0, "e_flush");
      step(mk(5'b11111, 0, 1, 2, 5, 1), 1'b0, "e_wr");
      chk("e_pre.pending2", 32'(pending[2]), 1);
      rst_n = 1'b0;
      #1;
      chk("e_rst.tick", 32'(tick), 0);
      chk("e_rst.pending", 32'(pending), 0);
      chk("e_rst.err", 32'(bus.cfg_err), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step(mk(5'b11111, 0, 0, 2, 0, 0), 1'b0, "e_post");
         if (k == 0) chk("e_post.pending2", 32'(obs_pend[2]), 0);
         chk($sformatf("e_post.tick0_%0d", k), 32'(obs_tick[0]), 32'(k % 4 == 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tick_generator.md
# tick_generator

Multi-channel programmable tick and clock-enable generator. It replaces fixed, compile-time single-ratio dividers with `NUM_CH` independent channels whose divisor and output mode can be changed at run time. Divisor updates apply glitch-free at the channel's period boundary. It sits beside the pixel/timing logic and feeds clock enables, for example pixel, blink and cursor-rate ticks, to the rest of the design; all outputs stay in the `clk` domain.

## Interface
- `NUM_CH`, default 4: number of independent channels, 1..16.
- `WIDTH`, default 16: counter/divisor width in bits; maximum divisor is 2^WIDTH-1.
- `DEFAULT_DIV`, default 4: divisor loaded into every channel at reset; must be < 2^WIDTH.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `ch_en`  in  NUM_CH  per-channel run enable.
- `sync_restart`  in  1  zero all counters and apply all pending updates.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config can be accepted.
- `cfg_chan`  in  $clog2(NUM_CH) (min 1)  target channel.
- `cfg_div`  in  WIDTH  new divisor.
- `cfg_mode`  in  1  0 = PULSE, 1 = SQUARE.
- `cfg_err`  out  1  one-cycle pulse: request targeted `cfg_chan` >= NUM_CH.
- `pending`  out  NUM_CH  channel holds an accepted, not yet applied update.
- `tick`  out  NUM_CH  per-channel output, in PULSE or SQUARE form according to the channel's mode.

## Operation
- Each channel holds:
  - active divisor D and active mode;
  - shadow divisor/mode with a `pending` flag;
  - counter `cnt`, WIDTH bits.
- Counting:
  - When `ch_en[i]`=1 and D>=1: `cnt` increments each cycle and wraps to 0 after D-1.
  - When `ch_en[i]`=0: `cnt` holds.
  - D=0: channel halted; `cnt` forced to 0.
- PULSE output: `tick[i]` = `ch_en[i]` && D!=0 && `cnt`==D-1. D=1 gives `tick` high every enabled cycle.
- SQUARE output:
  - `tick[i]` = 0 while `cnt` < floor(D/2), 1 otherwise. This gives 50% duty for even D; odd D is high one cycle longer.
  - Output holds its current level while disabled; it is 0 when D=0.
- Config handshake:
  - Transfer occurs when `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = !`pending[cfg_chan]` for an in-range channel, and 1 for an out-of-range channel.
  - An accepted in-range request writes the shadow registers and sets `pending`.
  - An accepted out-of-range request is dropped and pulses `cfg_err` on the next cycle.
- Update application: pending is copied to active and cleared on the edge where any of these holds:
  - (a) the channel wraps (`cnt`==D-1, enabled);
  - (b) `ch_en[i]`=0;
  - (c) D=0;
  - (d) `sync_restart`=1.
  On application `cnt` <= 0.
- `sync_restart`: all counters <= 0 on the next edge. It has priority over increment. It does not clear the active config.
- Simultaneous events:
  - A config transfer and an application in the same cycle on the same channel cannot occur, because `ready` is low while pending.
  - `sync_restart` coincident with a config transfer: the new request becomes pending and applies at the next boundary.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `cnt`=0, D=`DEFAULT_DIV`, mode=PULSE, `pending`=0.
  - `tick`=0 (PULSE with `cnt`=0 ≠ D-1 when `DEFAULT_DIV`>1), `cfg_err`=0.
- Outputs decode directly from registered state with zero added latency. `cfg_ready` is combinational from `cfg_chan` and `pending`.
- Cycle 0 = first edge after `rst_n` release with `ch_en`=1. With D=4 PULSE, `tick` is high during cycles 3, 7, 11, ...
- New divisor takes effect from the cycle after the old period's final cycle. No shortened or runt period is ever produced, except via `sync_restart` or `rst_n`.
- Reset asserted mid-period: outputs drop to reset values immediately and asynchronously; pending updates are lost.

## Structure
- Package `tick_gen_pkg`:
  - `tick_mode_e` {PULSE=1'b0, SQUARE=1'b1};
  - localparam for channel-index width;
  - the `DEFAULT_DIV` range check function.
- Sub-module `tick_channel`: one counter, active/shadow registers, output decode. Instantiated NUM_CH times in a generate loop.
- Top level holds the config decode, `cfg_ready` mux and `cfg_err` register.

## Test plan
- Reset, ch0 enabled, `DEFAULT_DIV`=4, PULSE -> `tick[0]` high cycles 3, 7, 11; `pending`=0; all `tick` 0 during reset.
- Write ch1 D=6 SQUARE mid-period -> `pending[1]`=1 and `cfg_ready` low for ch1 until the wrap. Afterwards `tick[1]` is low 3 / high 3 repeating, with no short period at the switch.
- `ch_en[2]` low for 5 cycles at `cnt`=2 (D=4) -> `tick[2]` 0 and `cnt` frozen. On re-enable, `tick` fires exactly 1 cycle later.
- D=1 PULSE -> `tick` constant 1 while enabled. D=0 -> `tick` 0 and a pending update applies the next cycle.
- `sync_restart` with ch0 D=4 and ch3 D=5, both mid-period -> both `cnt` 0 next cycle; ticks at +3 and +4 respectively.
- `cfg_chan`=NUM_CH with `cfg_valid` -> accepted (`cfg_ready`=1), `cfg_err` pulses one cycle, no channel state changes.
